program_loader: RTL and testbench
=================================

# program_loader

Byte-stream instruction loader for the 16-bit CPU's instruction RAM: the write side of the instruction path that the decoder reads. It accepts a framed byte stream (sync, word count, big-endian instruction words, optional checksum), assembles 16-bit words, and writes them to consecutive instruction RAM addresses from 0. While loading, it holds the CPU stopped. It sits between the host link (UART/byte FIFO) and the instruction-RAM write port, alongside the CPU's own `ram_wren_instr` path.

## Interface
Parameters:
- `ADDR_W`, 8, instruction RAM address width; maximum program length is 2^ADDR_W words.
- `SYNC_BYTE`, 8'hA5, frame start marker.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `byte_in`  in  8  stream byte.
- `byte_valid`  in  1  `byte_in` is valid this cycle.
- `byte_ready`  out  1  loader accepts `byte_in` this cycle. A transfer occurs only when valid and ready are both high.
- `ram_instr_addr`  out  ADDR_W  instruction RAM write address.
- `ram_instr_data`  out  16  instruction word to write.
- `ram_wren_instr`  out  1  one-cycle write strobe.
- `cpu_hold`  out  1  holds the CPU stopped and its PC cleared.
- `load_done`  out  1  one-cycle pulse on successful completion.
- `load_error`  out  1  sticky error flag.

## Operation
- Frame format:
  - `SYNC_BYTE`.
  - Count high byte, then count low byte (N words).
  - 2N data bytes, high byte first per word.
  - Checksum byte, only when `LOADER_CHECKSUM_EN` is defined.
- States: IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE.
- IDLE:
  - Accepts and discards bytes other than `SYNC_BYTE`.
  - On sync: clear `load_error`, set `cpu_hold`, reset the address and checksum, then go to CNT_HI.
- CNT_HI → CNT_LO.
- CNT_LO, after both count bytes are received:
  - N = 0: go to CHK if enabled, else DONE.
  - N > 2^ADDR_W: set `load_error` and go to IDLE. `cpu_hold` stays high.
  - Otherwise go to DATA_HI.
- DATA_HI → DATA_LO → WRITE.
- WRITE:
  - `ram_wren_instr` is high for exactly one cycle with the current address and word.
  - The address then increments and the remaining count decrements.
  - Next state is DATA_HI if words remain, else CHK or DONE.
- CHK:
  - The running XOR covers every accepted byte after sync: count bytes and data bytes.
  - Received byte equal to the running XOR: go to DONE.
  - Mismatch: set `load_error` and go to IDLE. `cpu_hold` stays high.
- DONE: pulse `load_done`, clear `cpu_hold`, go to IDLE.
- After an error, `cpu_hold` stays high until a later load succeeds or `reset` is asserted. The CPU never runs a partial image.
- `SYNC_BYTE` received mid-frame is treated as ordinary data; there is no resynchronisation inside a frame.
- Address arithmetic is ADDR_W bits wide. N = 2^ADDR_W fills RAM exactly, and the final address wraps to 0 with no further write.

## Timing
- Reset values:
  - State IDLE.
  - `byte_ready` = 1.
  - `ram_instr_addr` = 0, `ram_instr_data` = 0.
  - `ram_wren_instr` = 0, `cpu_hold` = 0, `load_done` = 0, `load_error` = 0.
- `byte_ready` is high in every state except WRITE and DONE.
- Sustained back-to-back bytes give 3 cycles per word: hi, lo, write.
- `cpu_hold` rises in the cycle after the sync transfer.
- `load_done` is asserted in the cycle after the last write (checksum disabled) or after the checksum byte.
- `reset` asserted mid-frame:
  - Next cycle the block is in IDLE with all outputs at reset values.
  - No write strobe is issued in that cycle.
- `byte_valid` is ignored when `byte_ready` is low. The source must hold its byte.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - CHK state and checksum accumulator are present.
  - The frame carries a trailing XOR byte.
- `LOADER_CHECKSUM_EN` undefined:
  - No CHK state and no accumulator.
  - The frame ends after the last data byte.
  - `load_error` is raised only on a count overflow.

## Structure
- Shared package `loader_pkg` holds:
  - the state enum;
  - the `SYNC_BYTE` default;
  - the count width constant (16).
- One sub-module, `loader_csum`:
  - 8-bit XOR accumulator with clear and enable;
  - instantiated only under `LOADER_CHECKSUM_EN`.

## Test plan
- Checksum enabled, stream A5 00 02 12 34 AB CD 42 → writes 0x1234 at address 0 and 0xABCD at address 1, `load_done` pulses, `cpu_hold` ends at 0, `load_error` 0.
- Same stream with checksum byte 43 → both words written, then `load_error` = 1, `cpu_hold` stays 1, no `load_done`.
- Stream FF 00 A5 00 00 00 (checksum enabled) → FF and 00 ignored in IDLE, no writes, `load_done` pulses.
- ADDR_W = 2, count 00 05 → `load_error` = 1 after the count low byte, no write strobes.
- Reset asserted after the high data byte of word 1 → next cycle all outputs are at reset values, with no spurious write.
- Continuous `byte_valid` stream → `byte_ready` low exactly during WRITE and DONE cycles, with no byte lost or duplicated.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-RAM byte-stream loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CHK,
    DONE
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         CNT_W             = 16;

endpackage

// File: rtl/loader_csum.sv
// 8-bit running XOR over the accepted frame bytes; clear wins over enable.
module loader_csum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data_in,
  output logic [7:0] sum
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum ^ data_in;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader for the CPU instruction RAM; holds the CPU while loading.
// Optional trailing XOR checksum is built when LOADER_CHECKSUM_EN is defined.
module program_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] ram_instr_addr,
  output logic [15:0]       ram_instr_data,
  output logic              ram_wren_instr,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  // Byte handshake: a byte moves only on a rising edge where byte_valid and
  // byte_ready are both high; byte_ready depends on state alone, so the source
  // must hold byte_in stable while ready is low.

  localparam logic [CNT_W:0] MAX_WORDS = (CNT_W + 1)'(1) << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CHK;
`else
  localparam state_t END_STATE = DONE;
`endif

  state_t             state;
  state_t             state_next;
  logic [7:0]         hi_q;
  logic [CNT_W-1:0]   rem_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [15:0]        data_q;
  logic               hold_q;
  logic               err_q;

  logic               xfer;
  logic               sync_seen;
  logic [CNT_W-1:0]   count_word;
  logic               overflow;

  assign xfer       = byte_valid && byte_ready;
  assign sync_seen  = (state == IDLE) && xfer && (byte_in == SYNC_BYTE);
  assign count_word = {hi_q, byte_in};
  assign overflow   = {1'b0, count_word} > MAX_WORDS;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_en;
  logic       csum_ok;

  // The sync byte itself is excluded; every later accepted byte up to the checksum is folded in.
  assign csum_en = xfer && (state inside {CNT_HI, CNT_LO, DATA_HI, DATA_LO});
  assign csum_ok = (byte_in == csum);

  loader_csum u_csum (
    .clk     (clk),
    .reset   (reset),
    .clear   (sync_seen),
    .en      (csum_en),
    .data_in (byte_in),
    .sum     (csum)
  );
`endif

  always_comb begin
    state_next     = state;
    byte_ready     = 1'b1;
    ram_wren_instr = 1'b0;
    load_done      = 1'b0;
    case (state)
      IDLE:    if (sync_seen) state_next = CNT_HI;
      CNT_HI:  if (xfer) state_next = CNT_LO;
      CNT_LO: begin
        if (xfer) begin
          if (count_word == '0)  state_next = END_STATE;
          else if (overflow)     state_next = IDLE;
          else                   state_next = DATA_HI;
        end
      end
      DATA_HI: if (xfer) state_next = DATA_LO;
      DATA_LO: if (xfer) state_next = WRITE;
      WRITE: begin
        byte_ready     = 1'b0;
        ram_wren_instr = 1'b1;
        state_next     = (rem_q == CNT_W'(1)) ? END_STATE : DATA_HI;
      end
`ifdef LOADER_CHECKSUM_EN
      CHK:     if (xfer) state_next = csum_ok ? DONE : IDLE;
`endif
      DONE: begin
        byte_ready = 1'b0;
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      hi_q   <= '0;
      rem_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      hold_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (sync_seen) begin
            err_q  <= 1'b0;
            hold_q <= 1'b1;
            addr_q <= '0;
          end
        end
        CNT_HI, DATA_HI: if (xfer) hi_q <= byte_in;
        CNT_LO: begin
          if (xfer) begin
            rem_q <= count_word;
            if (overflow) err_q <= 1'b1;
          end
        end
        DATA_LO: if (xfer) data_q <= {hi_q, byte_in};
        WRITE: begin
          // Wraps to 0 after a full-RAM image; no further write follows.
          addr_q <= addr_q + ADDR_W'(1);
          rem_q  <= rem_q - CNT_W'(1);
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: if (xfer && !csum_ok) err_q <= 1'b1;
`endif
        DONE: hold_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign ram_instr_addr = addr_q;
  assign ram_instr_data = data_q;
  assign cpu_hold       = hold_q;
  assign load_error     = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader (ADDR_W = 2): table vectors, hand sequences, random frames vs. a frame-level model.
module tb_program_loader;

  localparam int AW = 2;
  localparam int W  = AW + 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic [AW-1:0] ram_instr_addr;
  logic [15:0]   ram_instr_data;
  logic          ram_wren_instr;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;

  program_loader #(.ADDR_W(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .byte_in        (byte_in),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .ram_instr_addr (ram_instr_addr),
    .ram_instr_data (ram_instr_data),
    .ram_wren_instr (ram_wren_instr),
    .cpu_hold       (cpu_hold),
    .load_done      (load_done),
    .load_error     (load_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  int wr_seen   = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   frame_q[$];

  int m_done, m_err, m_hold, m_nw, m_addr;

  typedef struct {
    logic [127:0] bytes;
    int len;
    int done;
    int err;
    int hold;
    int nw;
    int addr;
  } vec_t;

  vec_t vecs[$];

  // Scoreboard / protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    n_checks++;
    if (byte_ready !== !(ram_wren_instr || load_done)) begin
      n_fail++;
      $display("FAIL ready_rule t=%0t ready=%b wren=%b done=%b", $time, byte_ready, ram_wren_instr, load_done);
    end
    if (load_done === 1'b1) done_seen++;
    if (ram_wren_instr === 1'b1) begin
      wr_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_write t=%0t addr=%0h data=%h expected no write", $time, ram_instr_addr, ram_instr_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({ram_instr_addr, ram_instr_data} !== e)
          begin
            n_fail++;
            $display("FAIL write t=%0t got addr=%0h data=%h required addr=%0h data=%h",
                     $time, ram_instr_addr, ram_instr_data, e[W-1:16], e[15:0]);
          end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waits;
    waits = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (byte_ready !== 1'b1 && waits < 8) begin
      waits++;
      @(negedge clk);
    end
    if (byte_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout byte=%h got ready=%b required 1 within 8 cycles", b, byte_ready);
    end
    @(posedge clk);
    #1;
  endtask

  // Frame-level reference: find sync, read count, list writes, judge checksum.
  task automatic model_frame();
    int i, n;
    logic [7:0] x;
    i = 0;
    while (frame_q[i] != SYNC) i++;
    n = int'({frame_q[i+1], frame_q[i+2]});
    m_hold = 1;
    m_err  = 0;
    m_done = 0;
    m_nw   = 0;
    m_addr = 0;
    if (n > (1 << AW)) begin
      m_err = 1;
      return;
    end
    x = frame_q[i+1] ^ frame_q[i+2];
    for (int k = 0; k < n; k++) begin
      logic [AW-1:0] a;
      a = AW'(k);
      exp_q.push_back({a, frame_q[i+3+2*k], frame_q[i+4+2*k]});
      x = x ^ frame_q[i+3+2*k] ^ frame_q[i+4+2*k];
    end
    m_nw   = n;
    m_addr = n % (1 << AW);
`ifdef LOADER_CHECKSUM_EN
    if (frame_q[i+3+2*n] == x) begin
      m_done = 1;
      m_hold = 0;
    end else begin
      m_err = 1;
    end
`else
    m_done = 1;
    m_hold = 0;
`endif
  endtask

  task automatic run_frame(input string tag, input int e_done, input int e_err, input int e_hold,
                           input int e_nw, input int e_addr, input bit gaps);
    int d0, w0;
    d0 = done_seen;
    w0 = wr_seen;
    foreach (frame_q[j]) begin
      send_byte(frame_q[j]);
      if (gaps && $urandom_range(0, 3) == 0) begin
        byte_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    byte_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done"}, done_seen - d0, e_done);
    check({tag, "_error"}, int'(load_error), e_err);
    check({tag, "_hold"}, int'(cpu_hold), e_hold);
    check({tag, "_writes"}, wr_seen - w0, e_nw);
    check({tag, "_addr"}, int'(ram_instr_addr), e_addr);
    check({tag, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic add_vec(input logic [127:0] v, input int len, input int d, input int e,
                         input int h, input int nw, input int ad);
    vec_t t;
    t.bytes = v; t.len = len; t.done = d; t.err = e; t.hold = h; t.nw = nw; t.addr = ad;
    vecs.push_back(t);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, int'(byte_ready), 1);
    check({tag, "_addr"}, int'(ram_instr_addr), 0);
    check({tag, "_data"}, int'(ram_instr_data), 0);
    check({tag, "_wren"}, int'(ram_wren_instr), 0);
    check({tag, "_hold"}, int'(cpu_hold), 0);
    check({tag, "_done"}, int'(load_done), 0);
    check({tag, "_error"}, int'(load_error), 0);
  endtask

  initial begin
    // Clock/reset
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Table-driven frames
`ifdef LOADER_CHECKSUM_EN
    add_vec(128'hA500021234ABCD42, 8, 1, 0, 0, 2, 2);
    add_vec(128'hA500021234ABCD43, 8, 0, 1, 1, 2, 2);
    add_vec(128'hFF00A5000000, 6, 1, 0, 0, 0, 0);
    add_vec(128'hA50005, 3, 0, 1, 1, 0, 0);
    add_vec(128'hA500041111222233334444_04, 12, 1, 0, 0, 4, 0);
    add_vec(128'hA50001A55AFE, 6, 1, 0, 0, 1, 1);
`else
    add_vec(128'hA500021234ABCD, 7, 1, 0, 0, 2, 2);
    add_vec(128'hA50005, 3, 0, 1, 1, 0, 0);
    add_vec(128'hFF00A50000, 5, 1, 0, 0, 0, 0);
    add_vec(128'hA50004111122223333444_4, 11, 1, 0, 0, 4, 0);
    add_vec(128'hA50001A55A, 5, 1, 0, 0, 1, 1);
`endif
    foreach (vecs[v]) begin
      frame_q.delete();
      for (int k = 0; k < vecs[v].len; k++)
        frame_q.push_back(vecs[v].bytes[8*(vecs[v].len-1-k) +: 8]);
      model_frame();
      run_frame($sformatf("vec%0d", v), vecs[v].done, vecs[v].err, vecs[v].hold,
                vecs[v].nw, vecs[v].addr, 1'b0);
    end

    // Hold rises the cycle after sync; reset mid-word kills the frame with no write
    check("pre_sync_hold", int'(cpu_hold), 0);
    send_byte(SYNC);
    check("post_sync_hold", int'(cpu_hold), 1);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    byte_in    = 8'h34;
    byte_valid = 1'b1;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    reset      = 1'b0;
    byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_no_write", int'(ram_wren_instr), 0);

    // Randomised frames, alternating back-to-back and gapped byte streams
    for (int f = 0; f < 40; f++) begin
      int sel, n;
      logic [7:0] b, x;
      frame_q.delete();
      repeat ($urandom_range(0, 2)) begin
        do b = 8'($urandom); while (b == SYNC);
        frame_q.push_back(b);
      end
      frame_q.push_back(SYNC);
      sel = $urandom_range(0, 6);
      n = (sel <= 4) ? sel : (sel == 5) ? 5 : $urandom_range(6, 65535);
      frame_q.push_back(8'(n >> 8));
      frame_q.push_back(8'(n));
      if (n <= (1 << AW)) begin
        x = 8'(n >> 8) ^ 8'(n);
        for (int k = 0; k < 2 * n; k++) begin
          b = 8'($urandom);
          x = x ^ b;
          frame_q.push_back(b);
        end
`ifdef LOADER_CHECKSUM_EN
        if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
        frame_q.push_back(x);
`endif
      end
      model_frame();
      run_frame($sformatf("rnd%0d", f), m_done, m_err, m_hold, m_nw, m_addr, f[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
